// File: rtl/accum_wr_ctrl_pkg.sv
// Shared parameters and FSM state encoding for the accumulator write-side controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default array/accumulator geometry, row/address derivation, accum_wr_state_e.
package neurex_pkg;

    localparam int DEF_SYS_COL    = 16;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ACCUM_SIZE = 1024;

    // Address width of one bank; a single-row bank still gets one address bit.
    function automatic int calc_addr_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    localparam int DEF_ACCUM_ROW  = DEF_ACCUM_SIZE / DEF_SYS_COL;
    localparam int DEF_ADDR_WIDTH = calc_addr_width(DEF_ACCUM_ROW);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } accum_wr_state_e;

endpackage

// File: rtl/accum_wr_ctrl_if.sv
// Command and per-bank strobe bundle between the write controller and the accumulator banks.
// Latency: n/a (wires only).
// Backpressure: none; en is a start pulse sampled only while the controller is idle.
// master: controller side (takes the command, drives strobes/addresses, busy, done).
// slave:  issuer/bank side (drives the command, observes everything else).
interface accum_wr_ctrl_if
    import neurex_pkg::*;
#(
    parameter int SYS_COL    = DEF_SYS_COL,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  en;
    logic                  accumulate;
    logic [DATA_WIDTH-1:0] num_row;
    logic [7:0]            first_lat;
    logic [ADDR_WIDTH-1:0] accum_rd_addr [0:SYS_COL-1];
    logic [SYS_COL-1:0]    accum_rd_en;
    logic [ADDR_WIDTH-1:0] accum_wr_addr [0:SYS_COL-1];
    logic [SYS_COL-1:0]    accum_wr_en;
    logic [SYS_COL-1:0]    accum_add_en;
    logic                  busy;
    logic                  done;

    modport master (
        input  en, accumulate, num_row, first_lat,
        output accum_rd_addr, accum_rd_en, accum_wr_addr, accum_wr_en, accum_add_en,
        output busy, done
    );

    modport slave (
        output en, accumulate, num_row, first_lat,
        input  accum_rd_addr, accum_rd_en, accum_wr_addr, accum_wr_en, accum_add_en,
        input  busy, done
    );
endinterface

// File: rtl/accum_wr_ctrl_skew_chain.sv
// Diagonal skew: column c sees the column-0 payload delayed by c cycles.
// Latency: column 0 is combinational pass-through, column c is c register stages.
// Backpressure: none; the chain advances every cycle.
// Ports: clk, rstn (sync, active-low), in_dat (column-0 payload), col_dat[c] (column c payload).
module skew_chain #(
    parameter int SYS_COL = 16,
    parameter int WIDTH   = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] in_dat,
    output logic [WIDTH-1:0] col_dat [0:SYS_COL-1]
);

    // stg[c] drives column c+1.
    logic [WIDTH-1:0] stg [0:SYS_COL-2];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < SYS_COL-1; i++) begin
                stg[i] <= '0;
            end
        end else begin
            stg[0] <= in_dat;
            for (int i = 1; i < SYS_COL-1; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign col_dat[0] = in_dat;

    for (genvar c = 1; c < SYS_COL; c++) begin : g_tap
        assign col_dat[c] = stg[c-1];
    end

endmodule

// File: rtl/accum_wr_ctrl.sv
// Accumulator write controller: skewed per-bank read-modify-write strobes, then a done pulse.
// Latency: col0 read at L+1 after the en edge, col0 write one cycle later, done at L+N+SYS_COL+1.
// Backpressure: none; en is ignored while busy, the next start is accepted the cycle after done.
// Ports: clk, rstn (sync, active-low), bus (accum_wr_ctrl_if.master: command in, strobes/busy/done out).
module accum_wr_ctrl
    import neurex_pkg::*;
#(
    parameter int SYS_COL    = DEF_SYS_COL,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACCUM_SIZE = DEF_ACCUM_SIZE
) (
    input logic             clk,
    input logic             rstn,
    accum_wr_ctrl_if.master bus
);

    localparam int ACCUM_ROW  = ACCUM_SIZE / SYS_COL;
    localparam int ADDR_WIDTH = calc_addr_width(ACCUM_ROW);
    localparam int NW         = ADDR_WIDTH + 1;          // holds 0..ACCUM_ROW
    localparam int DRN_W      = $clog2(SYS_COL + 1);
    localparam int PW         = 3 + 2*ADDR_WIDTH;        // {rd_en, rd_addr, wr_en, wr_addr, add_en}

    accum_wr_state_e       state;
    logic [7:0]            lat_cnt;
    logic [DRN_W-1:0]      drn_cnt;
    logic [ADDR_WIDTH-1:0] row;
    logic [NW-1:0]         n_rows;
    logic [NW-1:0]         n_clamp;
    logic                  acc_q;

    // Column-0 registers; iss_vld marks a read slot even when rd_en is held low (overwrite mode).
    logic                  iss_vld;
    logic                  rd_en0;
    logic [ADDR_WIDTH-1:0] rd_addr0;
    logic                  wr_en0;
    logic [ADDR_WIDTH-1:0] wr_addr0;
    logic                  add_en0;
    logic                  busy_q;
    logic                  done_q;

    assign n_clamp = (bus.num_row > DATA_WIDTH'(ACCUM_ROW)) ? NW'(ACCUM_ROW)
                                                            : bus.num_row[NW-1:0];

    // Outputs are registered from the current state, so they trail the state by one cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            lat_cnt  <= '0;
            drn_cnt  <= '0;
            row      <= '0;
            n_rows   <= '0;
            acc_q    <= 1'b0;
            iss_vld  <= 1'b0;
            rd_en0   <= 1'b0;
            rd_addr0 <= '0;
            wr_en0   <= 1'b0;
            wr_addr0 <= '0;
            add_en0  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q  <= (state != ST_IDLE);
            done_q  <= (state == ST_DONE);
            iss_vld <= (state == ST_RUN);
            rd_en0  <= (state == ST_RUN) && acc_q;
            if (state == ST_RUN) begin
                rd_addr0 <= row;
            end
            // Bank read latency is one cycle: the write follows its read slot directly.
            wr_en0  <= iss_vld;
            add_en0 <= iss_vld && acc_q;
            if (iss_vld) begin
                wr_addr0 <= rd_addr0;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.en) begin
                        acc_q   <= bus.accumulate;
                        n_rows  <= n_clamp;
                        row     <= '0;
                        lat_cnt <= bus.first_lat - 8'd1;
                        if (n_clamp == '0) begin
                            state <= ST_DONE;
                        end else if (bus.first_lat == 8'd0) begin
                            state <= ST_RUN;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt == 8'd0) begin
                        state <= ST_RUN;
                    end else begin
                        lat_cnt <= lat_cnt - 8'd1;
                    end
                end
                ST_RUN: begin
                    // Row counter stops at N-1, so addresses never wrap.
                    if ({1'b0, row} == n_rows - NW'(1)) begin
                        state   <= ST_DRAIN;
                        drn_cnt <= DRN_W'(SYS_COL - 1);
                    end else begin
                        row <= row + ADDR_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    // Leaves on the edge that issues the last column's final write.
                    if (drn_cnt == '0) begin
                        state <= ST_DONE;
                    end else begin
                        drn_cnt <= drn_cnt - DRN_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    logic [PW-1:0] col0_dat;
    logic [PW-1:0] col_dat [0:SYS_COL-1];

    assign col0_dat = {rd_en0, rd_addr0, wr_en0, wr_addr0, add_en0};

    skew_chain #(
        .SYS_COL (SYS_COL),
        .WIDTH   (PW)
    ) u_skew (
        .clk     (clk),
        .rstn    (rstn),
        .in_dat  (col0_dat),
        .col_dat (col_dat)
    );

    for (genvar c = 0; c < SYS_COL; c++) begin : g_col
        assign bus.accum_rd_en[c]   = col_dat[c][PW-1];
        assign bus.accum_rd_addr[c] = col_dat[c][PW-2 -: ADDR_WIDTH];
        assign bus.accum_wr_en[c]   = col_dat[c][ADDR_WIDTH+1];
        assign bus.accum_wr_addr[c] = col_dat[c][ADDR_WIDTH:1];
        assign bus.accum_add_en[c]  = col_dat[c][0];
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: doc/accum_wr_ctrl.md
# accum_wr_ctrl

Write-side controller for the accumulator banks. It sits directly upstream of the output-drain controller. On a start pulse it produces per-column, diagonally skewed read-modify-write strobes and addresses, so that each systolic-array column's partial sums land in accumulator rows 0..num_row-1. A single-cycle `done` pulse after the last column's last write starts the drain.

## Interface
- SYS_COL, 16, number of array columns / accumulator banks
- DATA_WIDTH, 16, width of the `num_row` operand
- ACCUM_SIZE, 1024, total accumulator entries
- ACCUM_ROW (localparam), ACCUM_SIZE/SYS_COL, rows per bank
- ADDR_WIDTH (localparam), $clog2(ACCUM_ROW), bank address width

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- en  in  1  start pulse; sampled only when idle
- accumulate  in  1  1 = add to existing bank contents, 0 = overwrite
- num_row  in  DATA_WIDTH  rows to write per column
- first_lat  in  8  array latency, in cycles, before column 0's first result
- accum_rd_addr[0:SYS_COL-1]  out  ADDR_WIDTH  per-bank read address
- accum_rd_en  out  SYS_COL  per-bank read strobe
- accum_wr_addr[0:SYS_COL-1]  out  ADDR_WIDTH  per-bank write address
- accum_wr_en  out  SYS_COL  per-bank write strobe
- accum_add_en  out  SYS_COL  1 = bank writes read-data + array data; 0 = array data only
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse

## Operation
- All outputs are registered. On reset every output is 0 and the FSM goes to IDLE.
- FSM states: IDLE, WAIT, RUN, DRAIN, DONE.
- **IDLE**
  - When `en`=1: latch `accumulate`, `first_lat`, and `num_row` clamped to ACCUM_ROW.
  - If the clamped count is 0, go to DONE; otherwise go to WAIT.
- **WAIT**
  - Count `first_lat` cycles, then go to RUN. When `first_lat`=0, WAIT lasts zero cycles.
- **RUN**
  - The column-0 row counter r runs 0..N-1, one row per cycle.
  - Column-0 read: `rd_en`=accumulate, `rd_addr`=r.
- **Column-0 write**
  - Occurs one cycle after the corresponding read (bank read latency is 1).
  - `wr_en`=1, `wr_addr`=r, `add_en`=accumulate.
- **Skew**
  - Column c's `rd_en`, `rd_addr`, `wr_en`, `wr_addr`, and `add_en` equal column 0's values delayed by c cycles, through a skew shift chain.
- **DRAIN**
  - Entered after r reaches N-1.
  - Waits until the column SYS_COL-1 write has issued, then goes to DONE.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
- When `accumulate`=0, all `rd_en` and `add_en` stay 0. Write addresses and timing are unchanged.
- `en` asserted while `busy`=1 is ignored, and the latched fields are unaffected.
- Deasserting `rstn` mid-operation zeros the skew chain within the same edge: no further strobes, no `done`.
- Addresses never exceed N-1 ≤ ACCUM_ROW-1, so no wrap-around occurs.

## Timing
Cycle k means the k-th rising edge after the edge that sampled `en`=1 in IDLE. L = `first_lat`, N = clamped `num_row`.
- Column c `rd_en`=1 at cycles L+1+c .. L+N+c, with `rd_addr` = cycle-(L+1+c).
- Column c `wr_en`=1 at cycles L+2+c .. L+N+1+c, with `wr_addr` = cycle-(L+2+c).
- `done`=1 at cycle L+N+SYS_COL+1.
- `busy`=1 from cycle 1 through the `done` cycle inclusive.
- With N=0: `done` at cycle 1, `busy` high for cycle 1 only, no strobes.
- A new `en` is accepted at the earliest one cycle after `done`. The drain controller may be launched by `done` directly.
- Between operations, addresses hold their last values while strobes are 0.

## Structure
- Shared package `neurex_pkg`: SYS_COL, DATA_WIDTH, ACCUM_SIZE defaults, ACCUM_ROW/ADDR_WIDTH derivation, and the FSM state enum `accum_wr_state_e`.
- Sub-module `skew_chain`:
  - Parameterised by SYS_COL and payload width.
  - Payload bundle: {rd_en, rd_addr, wr_en, wr_addr, add_en}.
  - Stage c feeds column c+1.
  - Synchronous reset zeros every stage.
- The top level holds the FSM, the latency counter, the row counter, and the one-cycle read-to-write register for column 0.

## Test plan
- SYS_COL=4, L=0, N=3, accumulate=1, `en` at cycle 0 -> col0 `rd_en` cycles 1-3 (addr 0,1,2); col0 `wr_en` cycles 2-4; col3 `wr_en` cycles 5-7; `done` at cycle 8 only; `busy` cycles 1-8.
- Same operation with accumulate=0 -> all `rd_en` and `add_en` 0 throughout; write timing identical; `done` at cycle 8.
- L=5, N=1 -> col0 `rd_en` at cycle 6 (addr 0); col0 `wr_en` at cycle 7; `done` at cycle 11 (SYS_COL=4).
- N=0 -> `done` at cycle 1, no strobes. N=200 with ACCUM_ROW=64 -> clamped to 64 rows: last col0 `wr_addr`=63, no wrap.
- Second `en` at cycle 3 of a running operation -> ignored; exactly one `done`, latched fields unchanged.
- `rstn`=0 at cycle 4 of an N=3 operation -> at cycle 5 all strobes and `busy` are 0, `done` never asserts; a fresh `en` afterwards runs normally.
